pipelined_control_unit: RTL



---
 rtl/rv32_ctrl_pkg.sv | 93 +++++++++
 rtl/rv32_decoder.sv | 140 ++++++++++++++
 rtl/pipelined_control_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32IM decode/control stage: ALU op codes,
// load/store/branch selectors, opcode constants, control word and FSM states.
package rv32_ctrl_pkg;

  localparam logic [4:0] ALU_NOP    = 5'b00000;
  localparam logic [4:0] ALU_ADD    = 5'b00001;
  localparam logic [4:0] ALU_AND    = 5'b00010;
  localparam logic [4:0] ALU_OR     = 5'b00011;
  localparam logic [4:0] ALU_XOR    = 5'b00100;
  localparam logic [4:0] ALU_SLL    = 5'b00101;
  localparam logic [4:0] ALU_SRL    = 5'b00110;
  localparam logic [4:0] ALU_SRA    = 5'b00111;
  localparam logic [4:0] ALU_SUB    = 5'b01000;
  localparam logic [4:0] ALU_MUL    = 5'b01001;
  localparam logic [4:0] ALU_MULH   = 5'b01010;
  localparam logic [4:0] ALU_MULHU  = 5'b01011;
  localparam logic [4:0] ALU_MULHSU = 5'b01100;
  localparam logic [4:0] ALU_DIV    = 5'b01101;
  localparam logic [4:0] ALU_DIVU   = 5'b01110;
  localparam logic [4:0] ALU_REM    = 5'b01111;
  localparam logic [4:0] ALU_REMU   = 5'b10000;
  localparam logic [4:0] ALU_SLT    = 5'b10001;
  localparam logic [4:0] ALU_SLTU   = 5'b10010;

  localparam logic [2:0] LD_LB    = 3'd1;
  localparam logic [2:0] LD_LH    = 3'd2;
  localparam logic [2:0] LD_LW    = 3'd3;
  localparam logic [2:0] LD_LBU   = 3'd4;
  localparam logic [2:0] LD_LHU   = 3'd5;
  localparam logic [2:0] LD_UPPER = 3'd6;

  localparam logic [1:0] ST_SB = 2'd1;
  localparam logic [1:0] ST_SH = 2'd2;
  localparam logic [1:0] ST_SW = 2'd3;

  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MD_WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0] aluop;
    logic       immflag;
    logic       jumpflag;
    logic       selectwrite;
    logic       writeenable;
    logic       read;
    logic       write;
    logic [2:0] loadsignal;
    logic [1:0] storesignal;
    logic [2:0] branchsignal;
  } ctrl_word_t;

  // alt selects SUB over ADD and SRA over SRL; callers only set it where legal
  function automatic logic [4:0] base_alu_op(input logic [2:0] funct3, input logic alt);
    logic [4:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32_decoder.sv
// Combinational RV32IM decoder: instruction word to unregistered control word,
// with an M-extension flag and an illegal-instruction bit.
module rv32_decoder
  import rv32_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0] instr_i,
  output ctrl_word_t  word_o,
  output logic        muldiv_o,
  output logic        illegal_o
);

  logic [6:0] opcode_s;
  logic [6:0] funct7_s;
  logic [2:0] funct3_s;
  logic       unused_s;

  assign opcode_s = instr_i[6:0];
  assign funct3_s = instr_i[14:12];
  assign funct7_s = instr_i[31:25];
  assign unused_s = ^{instr_i[24:15], instr_i[11:7]};

  // Opcode/funct decode; any illegal combination collapses to an all-zero word
  always_comb begin
    word_o    = '0;
    muldiv_o  = 1'b0;
    illegal_o = 1'b0;
    case (opcode_s)
      OPC_LUI: begin
        word_o.aluop       = ALU_NOP;
        word_o.immflag     = 1'b1;
        word_o.writeenable = 1'b1;
        word_o.loadsignal  = LD_UPPER;
      end
      OPC_AUIPC: begin
        word_o.aluop       = ALU_ADD;
        word_o.immflag     = 1'b1;
        word_o.writeenable = 1'b1;
        word_o.loadsignal  = LD_UPPER;
      end
      OPC_JAL: begin
        word_o.aluop       = ALU_ADD;
        word_o.immflag     = 1'b1;
        word_o.jumpflag    = 1'b1;
        word_o.writeenable = 1'b1;
      end
      OPC_JALR: begin
        if (funct3_s == 3'b000) begin
          word_o.aluop       = ALU_ADD;
          word_o.immflag     = 1'b1;
          word_o.jumpflag    = 1'b1;
          word_o.writeenable = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_BRANCH: begin
        case (funct3_s)
          3'b000:  begin word_o.aluop = ALU_SUB;  word_o.branchsignal = BR_BEQ;  end
          3'b001:  begin word_o.aluop = ALU_SUB;  word_o.branchsignal = BR_BNE;  end
          3'b100:  begin word_o.aluop = ALU_SLT;  word_o.branchsignal = BR_BLT;  end
          3'b101:  begin word_o.aluop = ALU_SLT;  word_o.branchsignal = BR_BGE;  end
          3'b110:  begin word_o.aluop = ALU_SLTU; word_o.branchsignal = BR_BLTU; end
          3'b111:  begin word_o.aluop = ALU_SLTU; word_o.branchsignal = BR_BGEU; end
          default: illegal_o = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        word_o.aluop       = ALU_ADD;
        word_o.immflag     = 1'b1;
        word_o.read        = 1'b1;
        word_o.selectwrite = 1'b1;
        case (funct3_s)
          3'b000:  word_o.loadsignal = LD_LB;
          3'b001:  word_o.loadsignal = LD_LH;
          3'b010:  word_o.loadsignal = LD_LW;
          3'b100:  word_o.loadsignal = LD_LBU;
          3'b101:  word_o.loadsignal = LD_LHU;
          default: illegal_o = 1'b1;
        endcase
      end
      OPC_STORE: begin
        word_o.aluop   = ALU_NOP;
        word_o.immflag = 1'b1;
        word_o.write   = 1'b1;
        case (funct3_s)
          3'b000:  word_o.storesignal = ST_SB;
          3'b001:  word_o.storesignal = ST_SH;
          3'b010:  word_o.storesignal = ST_SW;
          default: illegal_o = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        word_o.aluop       = base_alu_op(funct3_s, (funct3_s == 3'b101) && funct7_s[5]);
        word_o.immflag     = 1'b1;
        word_o.writeenable = 1'b1;
        if (funct3_s == 3'b001) begin
          illegal_o = (funct7_s != F7_BASE);
        end else if (funct3_s == 3'b101) begin
          illegal_o = (funct7_s != F7_BASE) && (funct7_s != F7_ALT);
        end else begin
          illegal_o = 1'b0;
        end
      end
      OPC_OP: begin
        word_o.writeenable = 1'b1;
        if (funct7_s == F7_BASE) begin
          word_o.aluop = base_alu_op(funct3_s, 1'b0);
        end else if (funct7_s == F7_ALT) begin
          word_o.aluop = base_alu_op(funct3_s, 1'b1);
          illegal_o    = (funct3_s != 3'b000) && (funct3_s != 3'b101);
        end else if ((funct7_s == F7_MULDIV) && ENABLE_M) begin
          muldiv_o = 1'b1;
          case (funct3_s)
            3'b000:  word_o.aluop = ALU_MUL;
            3'b001:  word_o.aluop = ALU_MULH;
            3'b010:  word_o.aluop = ALU_MULHSU;
            3'b011:  word_o.aluop = ALU_MULHU;
            3'b100:  word_o.aluop = ALU_DIV;
            3'b101:  word_o.aluop = ALU_DIVU;
            3'b110:  word_o.aluop = ALU_REM;
            3'b111:  word_o.aluop = ALU_REMU;
            default: word_o.aluop = ALU_MUL;
          endcase
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: illegal_o = 1'b1;
    endcase
    if (illegal_o) begin
      word_o   = '0;
      muldiv_o = 1'b0;
    end else begin
      muldiv_o = muldiv_o;
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Registered ID/EX control stage: decoded word register plus a stall FSM for
// data-memory handshakes and multi-cycle MUL/DIV.
module pipelined_control_unit
  import rv32_ctrl_pkg::*;
#(
  parameter bit          ENABLE_M       = 1'b1,
  parameter int unsigned MULDIV_LATENCY = 4,
  parameter int unsigned ALUOP_W        = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [31:0]        instruction_i,
  input  logic               instr_valid_i,
  input  logic               flush_i,
  input  logic               busywait_i,
  output logic [ALUOP_W-1:0] aluop_o,
  output logic               immflag_o,
  output logic               jumpflag_o,
  output logic               selectwrite_o,
  output logic               writeenable_o,
  output logic               read_o,
  output logic               write_o,
  output logic [2:0]         loadsignal_o,
  output logic [1:0]         storesignal_o,
  output logic [2:0]         branchsignal_o,
  output logic               illegal_o,
  output logic               stall_o
);

  localparam logic [3:0] MD_INIT = 4'(MULDIV_LATENCY - 32'd1);
  localparam bit         MD_STALLS = (MULDIV_LATENCY > 32'd1);

  ctrl_word_t dec_word_s;
  logic       dec_muldiv_s;
  logic       dec_illegal_s;

  ctrl_word_t run_word_d;
  logic       run_illegal_d;
  logic       run_md_d;

  state_e     state_q;
  logic [3:0] cnt_q;
  ctrl_word_t word_q;
  logic       illegal_q;

  rv32_decoder #(.ENABLE_M(ENABLE_M)) u_decoder (
    .instr_i   (instruction_i),
    .word_o    (dec_word_s),
    .muldiv_o  (dec_muldiv_s),
    .illegal_o (dec_illegal_s)
  );

  // Word to register when in RUN; flush and invalid slots beat an illegal flag
  always_comb begin
    run_word_d    = '0;
    run_illegal_d = 1'b0;
    run_md_d      = 1'b0;
    if (!instr_valid_i || flush_i) begin
      run_word_d = '0;
    end else if (dec_illegal_s) begin
      run_illegal_d = 1'b1;
    end else begin
      run_word_d = dec_word_s;
      if (dec_muldiv_s && MD_STALLS) begin
        run_word_d.writeenable = 1'b0;
        run_md_d               = 1'b1;
      end else begin
        run_md_d = 1'b0;
      end
    end
  end

  // Stall FSM and control-word register; wait states ignore all pipeline inputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_RUN;
      cnt_q     <= 4'd0;
      word_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          word_q    <= run_word_d;
          illegal_q <= run_illegal_d;
          if (run_word_d.read || run_word_d.write) begin
            state_q <= ST_MEM_WAIT;
          end else if (run_md_d) begin
            cnt_q   <= MD_INIT;
            state_q <= ST_MD_WAIT;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          illegal_q <= 1'b0;
          if (!busywait_i) begin
            word_q.read        <= 1'b0;
            word_q.write       <= 1'b0;
            word_q.writeenable <= word_q.read;
            state_q            <= ST_RUN;
          end else begin
            state_q <= ST_MEM_WAIT;
          end
        end
        ST_MD_WAIT: begin
          illegal_q <= 1'b0;
          if (cnt_q <= 4'd1) begin
            word_q.writeenable <= 1'b1;
            cnt_q              <= 4'd0;
            state_q            <= ST_RUN;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q   <= ST_RUN;
          cnt_q     <= 4'd0;
          word_q    <= '0;
          illegal_q <= 1'b0;
        end
      endcase
    end
  end

  assign aluop_o        = ALUOP_W'(word_q.aluop);
  assign immflag_o      = word_q.immflag;
  assign jumpflag_o     = word_q.jumpflag;
  assign selectwrite_o  = word_q.selectwrite;
  assign writeenable_o  = word_q.writeenable;
  assign read_o         = word_q.read;
  assign write_o        = word_q.write;
  assign loadsignal_o   = word_q.loadsignal;
  assign storesignal_o  = word_q.storesignal;
  assign branchsignal_o = word_q.branchsignal;
  assign illegal_o      = illegal_q;
  assign stall_o        = (state_q != ST_RUN);

endmodule
